// File: rtl/alu_self_test.sv
// Built-in self-test initiator for the 8-bit ALU: drives nine fixed vectors,
// waits a settle time per vector and checks Result/Zero against stored values.
module alu_self_test #(
  parameter int SETTLE_CYCLES = 1,
  parameter bit STOP_ON_FAIL  = 1'b1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Start,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [3:0] FailIdx,
  output logic [7:0] FailResult,
  output logic [3:0] ErrCount,
  output logic [3:0] ALUOp,
  output logic [7:0] A,
  output logic [7:0] B,
  input  logic [7:0] Result,
  input  logic       Zero,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
  } vec_t;

  function automatic vec_t rom(input logic [3:0] i);
    case (i)
      4'd0:    rom = '{op: 4'h0, a: 8'h01, b: 8'h04, res: 8'h05, z: 1'b0};
      4'd1:    rom = '{op: 4'h1, a: 8'h0A, b: 8'h05, res: 8'h0F, z: 1'b0};
      4'd2:    rom = '{op: 4'h2, a: 8'h0F, b: 8'h00, res: 8'h00, z: 1'b1};
      4'd3:    rom = '{op: 4'h3, a: 8'h0E, b: 8'h0F, res: 8'h01, z: 1'b0};
      4'd4:    rom = '{op: 4'h4, a: 8'hFE, b: 8'hFE, res: 8'h01, z: 1'b0};
      4'd5:    rom = '{op: 4'h5, a: 8'hBE, b: 8'hFE, res: 8'h01, z: 1'b0};
      4'd6:    rom = '{op: 4'h6, a: 8'h06, b: 8'hC0, res: 8'h03, z: 1'b0};
      4'd7:    rom = '{op: 4'h7, a: 8'h08, b: 8'hAA, res: 8'h00, z: 1'b1};
      4'd8:    rom = '{op: 4'h8, a: 8'h00, b: 8'h0F, res: 8'hF1, z: 1'b0};
      default: rom = '0;
    endcase
  endfunction

  state_e     state;
  logic [3:0] idx;
  logic [3:0] cnt;
  vec_t       vec;
  logic       mismatch;

  assign vec       = rom(idx);
  assign mismatch  = (Result != vec.res) || (Zero != vec.z);
  assign dbg_state = state;

  // Start/Busy/Done handshake: Start is a level sampled only in IDLE or DONE;
  // while Busy=1 it is ignored, and Done/Pass/Fail* stay stable until the
  // next accepted Start or Reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      idx        <= 4'd0;
      cnt        <= 4'd0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Pass       <= 1'b0;
      FailIdx    <= 4'd0;
      FailResult <= 8'd0;
      ErrCount   <= 4'd0;
      ALUOp      <= 4'd0;
      A          <= 8'd0;
      B          <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            idx        <= 4'd0;
            ErrCount   <= 4'd0;
            FailIdx    <= 4'd0;
            FailResult <= 8'd0;
            Pass       <= 1'b0;
            Done       <= 1'b0;
            Busy       <= 1'b1;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          ALUOp <= vec.op;
          A     <= vec.a;
          B     <= vec.b;
          cnt   <= 4'(SETTLE_CYCLES);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // cnt==1 is the edge on which the settle counter reaches zero.
          if (cnt == 4'd1) begin
            if (mismatch) begin
              ErrCount <= ErrCount + 4'd1;
              if (ErrCount == 4'd0) begin
                FailIdx    <= idx;
                FailResult <= Result;
              end
            end
            if ((mismatch && STOP_ON_FAIL) || idx == 4'd8) begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              Pass  <= !mismatch && (ErrCount == 4'd0);
              state <= DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= DRIVE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_self_test.md
# alu_self_test

Built-in self-test initiator for the 8-bit `ALU`. On `Start` it walks a fixed ROM of nine operation vectors (one per `ALUOp` encoding), drives `ALUOp`/`A`/`B` into the ALU, and waits a programmable settle time. It then compares the ALU's `Result`/`Zero` against stored expected values and reports pass/fail, the first failing vector and an error count. It sits beside the datapath ALU and runs at power-on or on demand from the control unit.

## Interface
- `SETTLE_CYCLES`, default 1: cycles `ALUOp`/`A`/`B` are held before `Result`/`Zero` are sampled. Legal range is 1–15.
- `STOP_ON_FAIL`, default 1: 1 stops at the first mismatch; 0 runs all vectors and counts errors.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  level, sampled in IDLE or DONE; begins a run.
- `Busy`  out  1  high from the cycle after Start is accepted until DONE is entered.
- `Done`  out  1  high in DONE; held until the next accepted Start or Reset.
- `Pass`  out  1  valid while Done=1; 1 means zero mismatches.
- `FailIdx`  out  4  index (0–8) of the first mismatching vector; 0 if none.
- `FailResult`  out  8  `Result` captured at the first mismatch; 0 if none.
- `ErrCount`  out  4  number of mismatching vectors in the run (0–9).
- `ALUOp`  out  4  registered op driven to the ALU.
- `A`  out  8  registered operand A driven to the ALU.
- `B`  out  8  registered operand B driven to the ALU.
- `Result`  in  8  ALU result.
- `Zero`  in  1  ALU zero flag.

## Operation
- Vector ROM, in the form idx: ALUOp, A, B → expected Result, expected Zero:
  - 0: 0000 add, 0x01, 0x04 → 0x05, 0
  - 1: 0001 or, 0x0A, 0x05 → 0x0F, 0
  - 2: 0010 and, 0x0F, 0x00 → 0x00, 1
  - 3: 0011 less-than (A<B), 0x0E, 0x0F → 0x01, 0
  - 4: 0100 equal, 0xFE, 0xFE → 0x01, 0
  - 5: 0101 not-equal, 0xBE, 0xFE → 0x01, 0
  - 6: 0110 shift right B>>A, 0x06, 0xC0 → 0x03, 0
  - 7: 0111 shift left B<<A, 0x08, 0xAA → 0x00, 1
  - 8: 1000 negate (−B), 0x00, 0x0F → 0xF1, 0
- A vector mismatches if `Result` differs from the expected result OR `Zero` differs from the expected flag.
- States:
  - IDLE: Start=1 goes to DRIVE; clears idx, ErrCount, FailIdx, FailResult and Pass.
  - DRIVE: loads `ALUOp`/`A`/`B` from ROM[idx]; loads the settle counter with SETTLE_CYCLES; goes to WAIT.
  - WAIT: decrements the settle counter. On the edge where it reaches 0, samples `Result`/`Zero` and compares.
    - On mismatch: ErrCount+1. If this is the first error, latch FailIdx=idx and FailResult=Result. If STOP_ON_FAIL=1, go to DONE.
    - Otherwise: if idx=8, go to DONE; else idx+1 and go to DRIVE.
  - DONE: Done=1. Pass is 1 if ErrCount=0, else 0. `ALUOp`/`A`/`B` hold their last values. Start=1 restarts exactly as from IDLE, with the same clears.
- Start is ignored while Busy=1.
- idx never exceeds 8 and does not wrap.

## Timing
- Reset values: `ALUOp`=0, `A`=0, `B`=0, Busy=0, Done=0, Pass=0, FailIdx=0, FailResult=0, ErrCount=0, state=IDLE.
- Reset asserted mid-run wins over every other event in that cycle; the run is abandoned with no Done.
- Start is accepted at edge E0. Busy=1 and state DRIVE start after E0.
- Vector k is driven at edge E0+1+k·(1+SETTLE_CYCLES) and compared SETTLE_CYCLES edges later.
- Full passing run: Done rises after edge E0+9·(1+SETTLE_CYCLES). That is 18 cycles with the default SETTLE_CYCLES=1; Busy falls in the same cycle.
- Early stop at vector k (STOP_ON_FAIL=1): Done rises after edge E0+(k+1)·(1+SETTLE_CYCLES).
- `Result`/`Zero` are consumed only on the compare edge; values at any other time are don't-care.

## Test plan
- Behavioural correct ALU, default parameters, Start pulse → Busy for 18 cycles; then Done=1, Pass=1, ErrCount=0, FailIdx=0; the ALUOp sequence observed is 0..8.
- Bench ALU corrupts op 0110 to return 0x06, STOP_ON_FAIL=1 → Done 14 cycles after Start; Pass=0, FailIdx=6, FailResult=0x06, ErrCount=1.
- Bench ALU forces Zero=0 always, STOP_ON_FAIL=0 → full 18-cycle run; Pass=0, ErrCount=2, FailIdx=2, FailResult=0x00.
- SETTLE_CYCLES=3; bench ALU output is only valid 3 cycles after inputs change (X before that) → Pass=1, Done at E0+36.
- Reset pulsed at cycle 7 of a run → all outputs return to reset values on the next cycle. A Start issued afterwards completes normally with Pass=1.
- Start held high through a run and into DONE → no restart while Busy; a new run begins at the first edge in DONE (Done drops, counters cleared).
